// File: rtl/controller.sv
// rtl/controller.sv - 8-phase sequencing FSM and strobe decoder for the 8-bit RISC CPU.
// Optional macro CTRL_HALT_FREEZE_EN: HLT parks the FSM in OP_ADDR until reset.
module controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       is_zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       halt,
   output logic       inc_pc,
   output logic       ld_ac,
   output logic       ld_pc,
   output logic       wr,
   output logic       data_e
);

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } state_t;

   state_t r_state;
   logic   w_hlt, w_skz, w_sto, w_jmp, w_aluop;
   logic   w_freeze;

   // An unknown opcode falls to the default arm, so it decodes as nothing.
   always_comb begin
      w_hlt   = 1'b0;
      w_skz   = 1'b0;
      w_sto   = 1'b0;
      w_jmp   = 1'b0;
      w_aluop = 1'b0;
      case (opcode)
         3'b000:                         w_hlt   = 1'b1;
         3'b001:                         w_skz   = 1'b1;
         3'b010, 3'b011, 3'b100, 3'b101: w_aluop = 1'b1;
         3'b110:                         w_sto   = 1'b1;
         3'b111:                         w_jmp   = 1'b1;
         default:                        w_aluop = 1'b0;
      endcase
   end

`ifdef CTRL_HALT_FREEZE_EN
   logic r_frozen;

   assign w_freeze = r_frozen || (r_state == OP_ADDR && w_hlt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= INST_ADDR;
         r_frozen <= 1'b0;
      end else if (w_freeze) begin
         r_frozen <= 1'b1;
      end else begin
         r_state <= (r_state == STORE) ? INST_ADDR : state_t'(r_state + 3'd1);
      end
   end
`else
   assign w_freeze = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= INST_ADDR;
      end else begin
         r_state <= (r_state == STORE) ? INST_ADDR : state_t'(r_state + 3'd1);
      end
   end
`endif

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      halt   = 1'b0;
      inc_pc = 1'b0;
      ld_ac  = 1'b0;
      ld_pc  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      if (w_freeze) begin
         halt = 1'b1;
      end else begin
         case (r_state)
            INST_ADDR:  sel = 1'b1;
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = w_hlt;
            end
            OP_FETCH:   rd = w_aluop;
            ALU_OP: begin
               rd     = w_aluop;
               inc_pc = w_skz && is_zero;
               ld_pc  = w_jmp;
               data_e = w_sto;
            end
            STORE: begin
               rd     = w_aluop;
               ld_ac  = w_aluop;
               ld_pc  = w_jmp;
               wr     = w_sto;
               data_e = w_sto;
            end
            default: sel = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - Directed and randomized self-checking bench for controller.
module tb_controller;

`ifdef CTRL_HALT_FREEZE_EN
   localparam bit FREEZE = 1'b1;
`else
   localparam bit FREEZE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic       is_zero = 1'b0;
   logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;

   int checks = 0;
   int errors = 0;
   int m_phase = 0;
   bit m_frozen = 1'b0;

   controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
      .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e)
   );

   always #5 clk = ~clk;

   // Vector order: {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}
   function automatic logic [8:0] expect_vec(int ph, logic [2:0] op, logic z, bit frozen);
      bit alu, sto, jmp;
      int o;
      alu = (op >= 3'd2) && (op <= 3'd5);
      sto = (op == 3'd6);
      jmp = (op == 3'd7);
      if (frozen || (FREEZE && ph == 4 && op == 3'd0)) return 9'b000100000;
      case (ph)
         0: return 9'b100000000;
         1: return 9'b110000000;
         2, 3: return 9'b111000000;
         4: return {3'b000, op == 3'd0, 1'b1, 4'b0000};
         5: return {1'b0, alu, 7'b0};
         6: return {1'b0, alu, 2'b00, (op == 3'd1) && z, 1'b0, jmp, 1'b0, sto};
         7: return {1'b0, alu, 3'b000, alu, jmp, sto, sto};
         default: o = 0;
      endcase
      return 9'h1ff;
   endfunction

   task automatic check(input string tag);
      logic [8:0] obs, exp;
      obs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
      exp = expect_vec(m_phase, opcode, is_zero, m_frozen);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s phase=%0d op=%0d z=%0b observed=%b expected=%b",
                tag, m_phase, opcode, is_zero, obs, exp);
      end
   endtask

   task automatic step(input logic [2:0] op, input logic z, input string tag);
      @(posedge clk);
      if (rst) begin
         if (m_frozen || (FREEZE && m_phase == 4 && opcode == 3'd0)) m_frozen = 1'b1;
         else m_phase = (m_phase + 1) % 8;
      end
      #2;
      opcode  = op;
      is_zero = z;
      #1;
      check(tag);
   endtask

   task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
      for (int i = 0; i < 8; i++) step(op, z, tag);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      m_phase = 0;
      m_frozen = 1'b0;
      #1;
      check("reset_async");
      @(posedge clk);
      #1;
      check("reset_held");
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1;
      check("reset_initial");
      do_reset();
      step(3'd0, 1'b0, "first_after_reset");
      // Realign to phase 0 so each directed instruction covers all 8 phases in order.
      while (m_phase != 7) step(3'd2, 1'b0, "align");
      run_instr(3'd0, 1'b0, "hlt");
      if (FREEZE) do_reset();
      while (m_phase != 7) step(3'd2, 1'b0, "align2");
      run_instr(3'd1, 1'b1, "skz_z1");
      run_instr(3'd1, 1'b0, "skz_z0");
      run_instr(3'd2, 1'b0, "add");
      run_instr(3'd5, 1'b1, "lda");
      run_instr(3'd6, 1'b0, "sto");
      run_instr(3'd7, 1'b0, "jmp");
      step(3'd7, 1'b0, "jmp_wrap");

      // Reset during STORE-bound STO instruction aborts it before wr can fire.
      while (m_phase != 6) step(3'd6, 1'b0, "sto_pre_abort");
      #1;
      rst = 1'b0;
      m_phase = 0;
      m_frozen = 1'b0;
      #1;
      check("abort_async");
      @(posedge clk);
      #1;
      check("abort_held");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 300; i++) begin
         logic [2:0] op;
         logic z;
         op = 3'($urandom_range(1, 7));
         z  = 1'($urandom_range(0, 1));
         step(op, z, "random");
         if ($urandom_range(0, 3) == 0) begin
            opcode  = 3'($urandom_range(1, 7));
            is_zero = 1'($urandom_range(0, 1));
            #1;
            check("random_midstate");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
